dmacopy: RTL and testbench

//  Block-copy DMA engine: the bus *initiator* counterpart to the stb/we/addr/ack responders on the system bus.

---
 rtl/dmacopy.sv | 230 +++++++++++++++++++++++
 tb/tb_dmacopy.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmacopy.sv
// Block-copy DMA initiator programmed through a 4-word responder port.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module dmacopy #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        m_req,
  input  logic        m_gnt,
  output logic        m_stb,
  output logic        m_we,
  output logic [21:0] m_addr,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  input  logic        m_ack,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_GAP_R = 3'd2,
    S_WR    = 3'd3,
    S_GAP_W = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [21:0]          r_src;
  logic [21:0]          r_dst;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [31:0]          r_buf;
  logic                 r_ack;
  logic                 r_busy;
  logic                 r_dn;
  logic                 r_err;
  logic                 r_abrt;
  logic                 r_abort_pend;
  logic                 r_done;

  logic                 w_acc;
  logic                 w_wr;
  logic                 w_start;
  logic                 w_cnt_zero;
  logic                 w_abort_req;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_timeout;
  logic [15:0]          w_rem16;
  logic                 w_unused;

  // Accept a CPU access only in the cycle before its ack, so a held strobe acts once
  assign w_acc       = stb & ~r_ack;
  assign w_wr        = w_acc & we;
  assign w_start     = w_wr & (addr == 2'd2) & data_in[31] & ~r_busy;
  assign w_cnt_zero  = (data_in[CNT_WIDTH-1:0] == {CNT_WIDTH{1'b0}});
  assign w_abort_req = w_wr & (addr == 2'd3) & r_busy;
  assign w_xfer      = m_stb & m_ack;
  assign w_last      = (r_remaining == {CNT_WIDTH{1'b0}}) | r_abort_pend;
  assign w_rem16     = 16'(r_remaining);
  assign w_unused    = &{1'b0, data_in};

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = m_stb & ~m_ack & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Per-transaction stall counter, cleared whenever not in a bus phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if ((r_state != S_RD) && (r_state != S_WR)) begin
      r_to_cnt <= {TO_W{1'b0}};
    end else if (m_stb && !m_ack) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_cnt_zero) w_state_nxt = S_RD;
        else                        w_state_nxt = S_IDLE;
      end
      S_RD: begin
        if (w_timeout)   w_state_nxt = S_IDLE;
        else if (w_xfer) w_state_nxt = S_GAP_R;
        else             w_state_nxt = S_RD;
      end
      S_GAP_R: w_state_nxt = S_WR;
      S_WR: begin
        if (w_timeout)   w_state_nxt = S_IDLE;
        else if (w_xfer) w_state_nxt = S_GAP_W;
        else             w_state_nxt = S_WR;
      end
      S_GAP_W: begin
        if (w_last) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_RD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Initiator outputs follow grant combinationally so m_stb drops with m_gnt
  always_comb begin
    m_stb  = 1'b0;
    m_we   = 1'b0;
    m_addr = 22'h0;
    m_dout = 32'h0;
    case (r_state)
      S_RD: begin
        m_stb  = m_gnt;
        m_addr = r_src;
      end
      S_WR: begin
        m_stb  = m_gnt;
        m_we   = 1'b1;
        m_addr = r_dst;
        m_dout = r_buf;
      end
      default: begin
        m_stb = 1'b0;
      end
    endcase
  end

  // Register file, status flags and copy datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src        <= 22'h0;
      r_dst        <= 22'h0;
      r_remaining  <= {CNT_WIDTH{1'b0}};
      r_buf        <= 32'h0;
      r_ack        <= 1'b0;
      r_busy       <= 1'b0;
      r_dn         <= 1'b0;
      r_err        <= 1'b0;
      r_abrt       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ack  <= w_acc;
      r_done <= 1'b0;
      if (w_wr && !r_busy) begin
        case (addr)
          2'd0:    r_src       <= data_in[21:0];
          2'd1:    r_dst       <= data_in[21:0];
          2'd2:    r_remaining <= data_in[CNT_WIDTH-1:0];
          default: r_src       <= r_src;
        endcase
      end
      if (w_abort_req) r_abort_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_err  <= 1'b0;
            r_abrt <= 1'b0;
            r_dn   <= w_cnt_zero;
            r_done <= w_cnt_zero;
            r_busy <= ~w_cnt_zero;
            r_abort_pend <= 1'b0;
          end
        end
        S_RD, S_WR: begin
          if (w_timeout) begin
            r_err        <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_abort_pend <= 1'b0;
          end else if (w_xfer && (r_state == S_RD)) begin
            r_buf <= m_din;
          end else if (w_xfer) begin
            r_src       <= r_src + 22'd1;
            r_dst       <= r_dst + 22'd1;
            r_remaining <= r_remaining - CNT_WIDTH'(1);
          end
        end
        S_GAP_W: begin
          // A pending abort wins over normal completion
          if (w_last) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_abort_pend <= 1'b0;
            r_abrt       <= r_abort_pend;
            r_dn         <= ~r_abort_pend;
          end
        end
        default: r_buf <= r_buf;
      endcase
    end
  end

  // Responder read mux
  always_comb begin
    data_out = 32'h0;
    case (addr)
      2'd0:    data_out = {10'h0, r_src};
      2'd1:    data_out = {10'h0, r_dst};
      2'd2:    data_out = {w_rem16, 12'h000, r_abrt, r_err, r_dn, r_busy};
      default: data_out = 32'h0;
    endcase
  end

  assign ack   = r_ack;
  assign m_req = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_dmacopy.sv
// Randomized self-checking bench for dmacopy against a word-list copy model.
module tb_dmacopy;
  logic        clk = 1'b0;
  logic        rst_n, stb, we, ack, m_req, m_gnt, m_stb, m_we, m_ack, done;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out, m_dout, m_din;
  logic [21:0] m_addr;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] seed    = 32'h0;
  bit          rand_bus = 1'b0, gnt_hold = 1'b0, ack_stuck = 1'b0, hold_wr_ack = 1'b0;
  logic        ack_en;
  bit          pend_valid = 1'b0, prev_wait = 1'b0;
  logic [21:0] pend_addr;
  logic        pend_we;
  logic [31:0] pend_dout;
  logic [21:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [21:0] ra_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [21:0] a, input logic [31:0] s);
    return ({10'd0, a} * 32'h9E37_79B1) ^ s;
  endfunction

  function automatic logic [31:0] st(input int rem, input bit ab, input bit er, input bit dn, input bit bz);
    return {16'(rem), 12'h000, ab, er, dn, bz};
  endfunction

  assign m_din = pat(m_addr, seed);
  assign m_ack = m_stb & ack_en;

  dmacopy dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ack(ack), .m_req(m_req), .m_gnt(m_gnt), .m_stb(m_stb),
    .m_we(m_we), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din), .m_ack(m_ack), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Bus responder: drives grant/ack at negedge, logs handshakes, checks protocol rules
  initial begin
    m_gnt  = 1'b0;
    ack_en = 1'b0;
    forever begin
      @(negedge clk);
      m_gnt  = gnt_hold ? 1'b0 : (rand_bus ? ($urandom_range(0, 3) != 0) : 1'b1);
      ack_en = (ack_stuck || (hold_wr_ack && m_we)) ? 1'b0 :
               (rand_bus ? ($urandom_range(0, 2) != 0) : 1'b1);
      #1;
      if (!rst_n) begin
        pend_valid = 1'b0;
        prev_wait  = 1'b0;
      end else begin
        if (!m_gnt) chk("stb_without_gnt", {31'd0, m_stb}, 32'd0);
`ifndef BUS_TIMEOUT_EN
        if (prev_wait && m_gnt) chk("stb_held", {31'd0, m_stb}, 32'd1);
`endif
        if (pend_valid && m_stb) begin
          chk("represent_addr", {10'd0, m_addr}, {10'd0, pend_addr});
          chk("represent_we", {31'd0, m_we}, {31'd0, pend_we});
          chk("represent_dout", m_dout, pend_dout);
        end
        if (m_stb && m_ack) begin
          if (m_we) begin
            wa_q.push_back(m_addr);
            wd_q.push_back(m_dout);
          end else begin
            ra_q.push_back(m_addr);
          end
          pend_valid = 1'b0;
        end else if (m_stb) begin
          pend_valid = 1'b1;
          pend_addr  = m_addr;
          pend_we    = m_we;
          pend_dout  = m_dout;
        end
        prev_wait = m_stb && !m_ack;
      end
    end
  end

  task automatic cpu_xfer(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] rd);
    bit seen;
    seen = 1'b0;
    rd   = 32'h0;
    @(negedge clk);
    stb = 1'b1; we = w; addr = a; data_in = d;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1'b1;
        rd   = data_out;
      end
    end
    stb = 1'b0; we = 1'b0;
    chk("cpu_ack", {31'd0, seen}, 32'd1);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    cpu_xfer(1'b1, a, d, dummy);
  endtask

  task automatic cpu_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cpu_xfer(1'b0, a, 32'h0, v);
    chk(tag, v, exp);
  endtask

  task automatic start_copy(input logic [21:0] s, input logic [21:0] d, input int cnt);
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    cpu_wr(2'd0, {10'd0, s});
    cpu_wr(2'd1, {10'd0, d});
    cpu_wr(2'd2, 32'h8000_0000 | 32'(cnt));
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c + 1;
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk("done_pulse_width", {31'd0, done}, 32'd0);
    end
  endtask

  // Expected: word i reads s+i and writes pattern(s+i) to d+i, 22-bit wrap
  task automatic verify(input string tag, input logic [21:0] s, input logic [21:0] d, input int n);
    logic [21:0] ea;
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
    chk({tag, "_nrd"}, 32'(ra_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wa_q.size()) begin
        ea = d + 22'(i);
        chk({tag, "_waddr"}, {10'd0, wa_q[i]}, {10'd0, ea});
        ea = s + 22'(i);
        chk({tag, "_wdata"}, wd_q[i], pat(ea, seed));
      end
      if (i < ra_q.size()) begin
        ea = s + 22'(i);
        chk({tag, "_raddr"}, {10'd0, ra_q[i]}, {10'd0, ea});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [21:0] s, d;
    int          cnt;
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_m_stb", {31'd0, m_stb}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", {10'd0, m_addr}, 32'h0);
    chk("rst_m_dout", m_dout, 32'h0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    cpu_chk("rst_status", 2'd2, 32'h0);

    // Basic 4-word copy with single-cycle acks: 16 clocks
    seed = 32'h1357_9BDF;
    start_copy(22'h100, 22'h200, 4);
    wait_done(200, cyc);
    chk("basic_cycles", 32'(cyc), 32'd16);
    verify("basic", 22'h100, 22'h200, 4);
    cpu_chk("basic_status", 2'd2, st(0, 0, 0, 1, 0));
    cpu_chk("basic_src", 2'd0, 32'h104);
    cpu_chk("basic_dst", 2'd1, 32'h204);

    // Zero count: immediate done, no bus traffic
    start_copy(22'h10, 22'h20, 0);
    chk("zero_done", {31'd0, done}, 32'd1);
    repeat (4) @(negedge clk);
    chk("zero_no_bus", 32'(wa_q.size() + ra_q.size()), 32'd0);
    cpu_chk("zero_status", 2'd2, 32'h0000_0002);

    // Address wrap
    seed = $urandom;
    start_copy(22'h3FFFFE, 22'h3FFFFF, 3);
    wait_done(200, cyc);
    verify("wrap", 22'h3FFFFE, 22'h3FFFFF, 3);
    cpu_chk("wrap_src", 2'd0, 32'h1);

    // Abort during the third word's read
    seed = $urandom;
    start_copy(22'h400, 22'h800, 10);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #2;
      if (wa_q.size() >= 2) break;
    end
    cpu_wr(2'd3, 32'h1);
    wait_done(200, cyc);
    verify("abort", 22'h400, 22'h800, 3);
    cpu_chk("abort_status", 2'd2, st(7, 1, 0, 0, 0));
    cpu_chk("abort_src", 2'd0, 32'h403);
    cpu_wr(2'd3, 32'h1);
    cpu_chk("idle_abort_status", 2'd2, st(7, 1, 0, 0, 0));

    // Register writes while busy are ignored
    seed = $urandom;
    rand_bus = 1'b1;
    start_copy(22'h1000, 22'h2000, 3);
    cpu_wr(2'd0, 32'h0000_5555);
    cpu_wr(2'd2, 32'h8000_0005);
    wait_done(500, cyc);
    verify("busywr", 22'h1000, 22'h2000, 3);
    cpu_chk("busywr_src", 2'd0, 32'h1003);
    cpu_chk("busywr_status", 2'd2, st(0, 0, 0, 1, 0));
    rand_bus = 1'b0;

    // Grant removed for 5 cycles mid-write
    seed = $urandom;
    hold_wr_ack = 1'b1;
    start_copy(22'h30, 22'h60, 2);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #2;
      if (m_stb && m_we) break;
    end
    gnt_hold = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("gnt_low_stb", {31'd0, m_stb}, 32'd0);
    gnt_hold = 1'b0;
    hold_wr_ack = 1'b0;
    wait_done(200, cyc);
    verify("gntdrop", 22'h30, 22'h60, 2);

    // Randomized copies with random grant and wait states
    rand_bus = 1'b1;
    for (int it = 0; it < 8; it++) begin
      seed = $urandom;
      s = 22'($urandom);
      if (it % 3 == 0) s = 22'h3FFFF8 + 22'($urandom_range(0, 7));
      d = 22'($urandom);
      cnt = $urandom_range(1, 12);
      start_copy(s, d, cnt);
      wait_done(2000, cyc);
      verify("rand", s, d, cnt);
      cpu_chk("rand_status", 2'd2, st(0, 0, 0, 1, 0));
      cpu_chk("rand_src", 2'd0, {10'd0, s + 22'(cnt)});
    end
    rand_bus = 1'b0;

    // Stuck acknowledge
    seed = $urandom;
    ack_stuck = 1'b1;
    start_copy(22'h77, 22'h99, 1);
    repeat (40) @(negedge clk);
    #2;
`ifdef BUS_TIMEOUT_EN
    wait_done(1200, cyc);
    pend_valid = 1'b0;
    chk("timeout_stb", {31'd0, m_stb}, 32'd0);
    cpu_chk("timeout_status", 2'd2, st(1, 0, 1, 0, 0));
    ack_stuck = 1'b0;
`else
    chk("stuck_stb", {31'd0, m_stb}, 32'd1);
    chk("stuck_no_done", {31'd0, done}, 32'd0);
    cpu_chk("stuck_status", 2'd2, st(1, 0, 0, 0, 1));
    ack_stuck = 1'b0;
    wait_done(100, cyc);
    verify("stuck", 22'h77, 22'h99, 1);
    cpu_chk("stuck_status_end", 2'd2, st(0, 0, 0, 1, 0));
`endif

    // Reset in the middle of a transfer
    start_copy(22'h500, 22'h600, 8);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_stb", {31'd0, m_stb}, 32'd0);
    chk("midrst_m_req", {31'd0, m_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_chk("midrst_status", 2'd2, 32'h0);
    cpu_chk("midrst_src", 2'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
